// File: rtl/fma_result_writeback.sv
`default_nettype none
// ============================================================================
// Module      : fma_result_writeback
// Description : Captures tagged FMA result vectors into a small FIFO and
//               serialises them into SRAM write beats over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fma_result_writeback #(
    parameter int BW_FP      = 17,
    parameter int LANES      = 128,
    parameter int BEAT_LANES = 32,
    parameter int BW_ADDR    = 12,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        res_valid,
    input  logic [1:0]                  res_tag,
    input  logic [2:0]                  res_beats,
    input  logic [BW_ADDR-1:0]          res_addr,
    input  logic [LANES*BW_FP-1:0]      res_data,
    output logic                        res_ready,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [BW_ADDR-1:0]          wr_addr,
    output logic [BEAT_LANES*BW_FP-1:0] wr_data,
    output logic [1:0]                  wr_tag,
    output logic                        wr_last,
    output logic [2:0]                  done_pulse,
    output logic                        overflow_err,
    output logic                        busy
);

    localparam int             c_MAX_BEATS   = LANES / BEAT_LANES;
    localparam int             c_VEC_W       = LANES * BW_FP;
    localparam int             c_BEAT_W      = BEAT_LANES * BW_FP;
    localparam int             c_PTR_W       = $clog2(DEPTH);
    localparam logic [2:0]     c_MAX_BEATS_3 = 3'(c_MAX_BEATS);
    localparam logic [c_PTR_W:0] c_PTR_ONE   = (c_PTR_W+1)'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [c_VEC_W-1:0]  r_mem_data  [DEPTH];
    logic [1:0]          r_mem_tag   [DEPTH];
    logic [2:0]          r_mem_beats [DEPTH];
    logic [BW_ADDR-1:0]  r_mem_addr  [DEPTH];

    logic [c_PTR_W:0]    r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [2:0]          r_beat_cnt, w_beat_cnt_nxt;
    logic [2:0]          r_done, w_done_nxt;
    logic                r_overflow;
    state_t              r_state, w_state_nxt;

    logic [c_PTR_W-1:0]  w_head_idx, w_tail_idx;
    logic [c_VEC_W-1:0]  w_head_data;
    logic [c_BEAT_W-1:0] w_beat_data;
    logic [2:0]          w_beats_clamped;
    logic                w_full, w_send, w_last, w_hs, w_pop;
    logic                w_accept_req, w_push, w_drop;

    assign w_head_idx  = r_rd_ptr[c_PTR_W-1:0];
    assign w_tail_idx  = r_wr_ptr[c_PTR_W-1:0];
    assign w_full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                         (w_tail_idx == w_head_idx);
    assign w_send      = (r_state == S_SEND);
    assign w_head_data = r_mem_data[w_head_idx];
    assign w_last      = (r_beat_cnt == (r_mem_beats[w_head_idx] - 3'd1));
    assign w_hs        = w_send & wr_ready;
    assign w_pop       = w_hs & w_last;

    // A pop on the same edge frees a slot, so a push into a full FIFO can still land.
    assign w_accept_req = res_valid & (res_tag != 2'd0);
    assign w_push       = w_accept_req & (~w_full | w_pop);
    assign w_drop       = w_accept_req & w_full & ~w_pop;

    always_comb begin
        w_beats_clamped = res_beats;
        if (res_beats == 3'd0)
            w_beats_clamped = 3'd1;
        else if (res_beats > c_MAX_BEATS_3)
            w_beats_clamped = c_MAX_BEATS_3;
    end

    always_comb begin
        w_beat_data = '0;
        for (int b = 0; b < c_MAX_BEATS; b++) begin
            if (r_beat_cnt == 3'(b))
                w_beat_data = w_head_data[b*c_BEAT_W +: c_BEAT_W];
        end
    end

    // SEND is held exactly while the FIFO is non-empty, giving 1-cycle latency and no bubbles.
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_done_nxt     = 3'd0;
        if (w_push)
            w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
        if (w_pop) begin
            w_rd_ptr_nxt   = r_rd_ptr + c_PTR_ONE;
            w_beat_cnt_nxt = 3'd0;
            case (r_mem_tag[w_head_idx])
                2'd1:    w_done_nxt = 3'b001;
                2'd2:    w_done_nxt = 3'b010;
                2'd3:    w_done_nxt = 3'b100;
                default: w_done_nxt = 3'b000;
            endcase
        end else if (w_hs) begin
            w_beat_cnt_nxt = r_beat_cnt + 3'd1;
        end
        w_state_nxt = (w_wr_ptr_nxt != w_rd_ptr_nxt) ? S_SEND : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_beat_cnt <= 3'd0;
            r_done     <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_done     <= w_done_nxt;
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[w_tail_idx]  <= res_data;
            r_mem_tag[w_tail_idx]   <= res_tag;
            r_mem_beats[w_tail_idx] <= w_beats_clamped;
            r_mem_addr[w_tail_idx]  <= res_addr;
        end
    end

    assign res_ready    = ~w_full | w_pop;
    assign wr_valid     = w_send;
    assign wr_addr      = w_send ? (r_mem_addr[w_head_idx] + BW_ADDR'(r_beat_cnt)) : '0;
    assign wr_data      = w_send ? w_beat_data : '0;
    assign wr_tag       = w_send ? r_mem_tag[w_head_idx] : 2'd0;
    assign wr_last      = w_send & w_last;
    assign done_pulse   = r_done;
    assign overflow_err = r_overflow;
    assign busy         = (r_wr_ptr != r_rd_ptr);

endmodule
`default_nettype wire
